// File: rtl/inst_encoder.sv
// Packs decoded render commands into 32-bit parser instruction words.
// Commands carrying a second data field go out as a base word plus a continuation word.
module inst_encoder #(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_index,
  input  logic [4:0]       cmd_prop,
  input  logic [15:0]      cmd_data,
  input  logic             cmd_has_data2,
  input  logic [15:0]      cmd_data2,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [31:0]      word,
  output logic             word_last,
  output logic [CNT_W-1:0] words_sent,
  output logic             err_illegal,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W0   = 2'd1,
    W1   = 2'd2
  } state_t;

  localparam logic [2:0]       OP_CONT = 3'b111;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t        state_r;
  logic          alive_r;
  logic          has2_r;
  logic [15:0]   data2_r;
  logic          hs_s;
  logic          accept_s;
  logic          illegal_s;

  function automatic logic [31:0] pack_base(
    input logic [2:0]  op,
    input logic [7:0]  index,
    input logic [4:0]  prop,
    input logic [15:0] data
  );
    return {data, prop, index, op};
  endfunction

  function automatic logic [31:0] pack_cont(input logic [15:0] data2);
    return {data2, 13'd0, OP_CONT};
  endfunction

  // Handshake decode; alive_r keeps cmd_ready low until the first edge after reset.
  always_comb begin
    hs_s      = word_valid & word_ready;
    cmd_ready = alive_r & ((state_r == IDLE) | (hs_s & word_last));
    accept_s  = cmd_valid & cmd_ready;
    illegal_s = accept_s & (cmd_op == OP_CONT);
  end

  // Encoder FSM with registered word, flags and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      alive_r     <= 1'b0;
      has2_r      <= 1'b0;
      data2_r     <= 16'd0;
      word_valid  <= 1'b0;
      word        <= 32'd0;
      word_last   <= 1'b0;
      words_sent  <= '0;
      err_illegal <= 1'b0;
      err_cnt     <= '0;
    end else begin
      alive_r     <= 1'b1;
      err_illegal <= illegal_s;
      if (hs_s) begin
        words_sent <= words_sent + CNT_ONE;
      end
      if (illegal_s && (err_cnt != ERR_MAX)) begin
        err_cnt <= err_cnt + ERR_ONE;
      end
      // Acceptance only happens in IDLE or on the final-word handshake, so it overrides the state step.
      if (accept_s) begin
        if (illegal_s) begin
          state_r    <= IDLE;
          word_valid <= 1'b0;
        end else begin
          state_r    <= W0;
          word_valid <= 1'b1;
          word       <= pack_base(cmd_op, cmd_index, cmd_prop, cmd_data);
          word_last  <= ~cmd_has_data2;
          has2_r     <= cmd_has_data2;
          data2_r    <= cmd_data2;
        end
      end else begin
        case (state_r)
          IDLE: begin
            word_valid <= 1'b0;
          end
          W0: begin
            if (hs_s) begin
              if (has2_r) begin
                state_r   <= W1;
                word      <= pack_cont(data2_r);
                word_last <= 1'b1;
              end else begin
                state_r    <= IDLE;
                word_valid <= 1'b0;
              end
            end
          end
          W1: begin
            if (hs_s) begin
              state_r    <= IDLE;
              word_valid <= 1'b0;
            end
          end
          default: begin
            state_r    <= IDLE;
            word_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed-vector bench for inst_encoder with hand-computed expected words.
module tb_inst_encoder;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_index;
  logic [4:0]  cmd_prop;
  logic [15:0] cmd_data;
  logic        cmd_has_data2;
  logic [15:0] cmd_data2;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word;
  logic        word_last;
  logic [15:0] words_sent;
  logic        err_illegal;
  logic [7:0]  err_cnt;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  inst_encoder #(.CNT_W(16), .ERR_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_index    (cmd_index),
    .cmd_prop     (cmd_prop),
    .cmd_data     (cmd_data),
    .cmd_has_data2(cmd_has_data2),
    .cmd_data2    (cmd_data2),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .word         (word),
    .word_last    (word_last),
    .words_sent   (words_sent),
    .err_illegal  (err_illegal),
    .err_cnt      (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    else pass_cnt++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [2:0] op, input logic [7:0] idx, input logic [4:0] prop,
                         input logic [15:0] d, input logic h2, input logic [15:0] d2);
    cmd_op        = op;
    cmd_index     = idx;
    cmd_prop      = prop;
    cmd_data      = d;
    cmd_has_data2 = h2;
    cmd_data2     = d2;
  endtask

  // Presents one command, waits (bounded) for cmd_ready, returns just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [7:0] idx, input logic [4:0] prop,
                      input logic [15:0] d, input logic h2, input logic [15:0] d2);
    int n;
    set_cmd(op, idx, prop, d, h2, d2);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (!cmd_ready) check_eq("send_timeout", 32'd0, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  logic [31:0] stream_exp [4];

  initial begin
    stream_exp[0] = 32'h01000002;
    stream_exp[1] = 32'h0200000A;
    stream_exp[2] = 32'h03000012;
    stream_exp[3] = 32'h0400001A;

    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    word_ready = 1'b0;
    set_cmd(3'd0, 8'd0, 5'd0, 16'd0, 1'b0, 16'd0);
    repeat (3) tick();
    check_eq("rst_cmd_ready",  32'(cmd_ready),  32'd0);
    check_eq("rst_word_valid", 32'(word_valid), 32'd0);
    check_eq("rst_word",       word,            32'd0);
    check_eq("rst_words_sent", 32'(words_sent), 32'd0);
    check_eq("rst_err_cnt",    32'(err_cnt),    32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    // ctrl new render / new frame
    send(3'd0, 8'h00, 5'd0, 16'h0000, 1'b0, 16'h0000);
    check_eq("ctrl0_valid", 32'(word_valid), 32'd1);
    check_eq("ctrl0_word",  word,            32'h00000000);
    check_eq("ctrl0_last",  32'(word_last),  32'd1);
    check_eq("ctrl0_ready", 32'(cmd_ready),  32'd0);
    word_ready = 1'b1;
    tick();
    check_eq("ctrl0_done",  32'(word_valid), 32'd0);
    check_eq("ctrl0_sent",  32'(words_sent), 32'd1);
    word_ready = 1'b0;
    send(3'd0, 8'h40, 5'd0, 16'h0000, 1'b0, 16'h0000);
    check_eq("ctrl40_word", word, 32'h00000200);
    word_ready = 1'b1;
    tick();
    check_eq("ctrl40_sent", 32'(words_sent), 32'd2);
    word_ready = 1'b0;

    // camera set
    send(3'd1, 8'h00, 5'd1, 16'h555F, 1'b0, 16'h0000);
    check_eq("cam_word", word, 32'h555F0801);
    word_ready = 1'b1;
    tick();
    check_eq("cam_sent", 32'(words_sent), 32'd3);
    word_ready = 1'b0;

    // two-word shape with backpressure on the base word
    send(3'd3, 8'h05, 5'h02, 16'h1234, 1'b1, 16'hABCD);
    check_eq("shape_w0",       word,            32'h1234102B);
    check_eq("shape_w0_last",  32'(word_last),  32'd0);
    check_eq("shape_w0_ready", 32'(cmd_ready),  32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("bp_word",  word,            32'h1234102B);
      check_eq("bp_valid", 32'(word_valid), 32'd1);
      check_eq("bp_ready", 32'(cmd_ready),  32'd0);
      check_eq("bp_sent",  32'(words_sent), 32'd3);
    end
    word_ready = 1'b1;
    tick();
    check_eq("shape_w1",       word,            32'hABCD0007);
    check_eq("shape_w1_last",  32'(word_last),  32'd1);
    check_eq("shape_w1_sent",  32'(words_sent), 32'd4);
    check_eq("shape_w1_ready", 32'(cmd_ready),  32'd1);
    tick();
    check_eq("shape_done",     32'(word_valid), 32'd0);
    check_eq("shape_sent",     32'(words_sent), 32'd5);

    // four single-word lights streamed back to back
    set_cmd(3'd2, 8'd0, 5'd0, 16'h0100, 1'b0, 16'h0000);
    cmd_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("stream_valid", 32'(word_valid), 32'd1);
      check_eq("stream_word",  word,            stream_exp[i]);
      check_eq("stream_sent",  32'(words_sent), 32'(5 + i));
      if (i < 3) set_cmd(3'd2, 8'(i + 1), 5'd0, 16'((i + 2) * 256), 1'b0, 16'h0000);
      else cmd_valid = 1'b0;
      tick();
    end
    check_eq("stream_done", 32'(word_valid), 32'd0);
    check_eq("stream_sent_end", 32'(words_sent), 32'd9);

    // illegal command
    send(3'd7, 8'h00, 5'd0, 16'h0000, 1'b0, 16'h0000);
    check_eq("ill_valid",  32'(word_valid),  32'd0);
    check_eq("ill_pulse",  32'(err_illegal), 32'd1);
    check_eq("ill_cnt",    32'(err_cnt),     32'd1);
    tick();
    check_eq("ill_pulse_off", 32'(err_illegal), 32'd0);
    check_eq("ill_sent",      32'(words_sent),  32'd9);

    // illegal accepted on the same edge as a last-word handshake
    send(3'd2, 8'h01, 5'd0, 16'h0100, 1'b0, 16'h0000);
    check_eq("combo_word", word, 32'h0100000A);
    set_cmd(3'd7, 8'h00, 5'd0, 16'h0000, 1'b0, 16'h0000);
    cmd_valid = 1'b1;
    tick();
    check_eq("combo_valid", 32'(word_valid),  32'd0);
    check_eq("combo_pulse", 32'(err_illegal), 32'd1);
    check_eq("combo_cnt",   32'(err_cnt),     32'd2);
    check_eq("combo_sent",  32'(words_sent),  32'd10);

    // drive err_cnt to saturation
    repeat (253) tick();
    check_eq("sat_reach", 32'(err_cnt), 32'd255);
    tick();
    check_eq("sat_hold",  32'(err_cnt),     32'd255);
    check_eq("sat_pulse", 32'(err_illegal), 32'd1);
    cmd_valid = 1'b0;
    tick();
    check_eq("sat_pulse_off", 32'(err_illegal), 32'd0);

    // asynchronous reset while the continuation word is pending
    word_ready = 1'b0;
    send(3'd3, 8'h05, 5'h02, 16'h1234, 1'b1, 16'hABCD);
    check_eq("rstw_w0", word, 32'h1234102B);
    word_ready = 1'b1;
    tick();
    check_eq("rstw_w1", word, 32'hABCD0007);
    word_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstw_valid", 32'(word_valid), 32'd0);
    check_eq("rstw_word",  word,            32'd0);
    check_eq("rstw_sent",  32'(words_sent), 32'd0);
    check_eq("rstw_err",   32'(err_cnt),    32'd0);
    check_eq("rstw_ready", 32'(cmd_ready),  32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send(3'd1, 8'h00, 5'd1, 16'h555F, 1'b0, 16'h0000);
    check_eq("post_rst_word", word,           32'h555F0801);
    check_eq("post_rst_last", 32'(word_last), 32'd1);
    word_ready = 1'b1;
    tick();
    check_eq("post_rst_sent", 32'(words_sent), 32'd1);

    // stream until words_sent reaches 0xFFFF, then wrap on one more handshake
    set_cmd(3'd0, 8'h00, 5'd0, 16'h0000, 1'b0, 16'h0000);
    cmd_valid = 1'b1;
    repeat (65535) tick();
    check_eq("wrap_pre",       32'(words_sent), 32'h0000FFFF);
    check_eq("wrap_pre_valid", 32'(word_valid), 32'd1);
    cmd_valid = 1'b0;
    tick();
    check_eq("wrap_post",       32'(words_sent), 32'd0);
    check_eq("wrap_post_valid", 32'(word_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
